// File: rtl/cache_port_arbiter_pkg.sv
// cache_arb_pkg: shared FSM state, command record and default sizes for the cache port arbiter.
// The command record is sized by the package widths, so the arbiter keeps ADDR_WIDTH/DATA_WIDTH at these defaults.
package cache_arb_pkg;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 6;
   localparam int TIMEOUT_DEF = 64;
   localparam int CNT_W = 8;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
   typedef struct packed {
      logic              idx;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_cmd_t;
endpackage

// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: requester and cache-side bus of the arbiter; master drives requests and cache responses.
interface cache_port_arbiter_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 6,
   parameter int CNT_WIDTH = 8
);
   logic                  req0, req1, we0, we1;
   logic [ADDR_WIDTH-1:0] addr0, addr1;
   logic [DATA_WIDTH-1:0] wdata0, wdata1;
   logic                  ack0, ack1, hit_out0, hit_out1, err0, err1;
   logic [DATA_WIDTH-1:0] rdata0, rdata1;
   logic [ADDR_WIDTH-1:0] cache_addr;
   logic                  cache_read, cache_write;
   logic [DATA_WIDTH-1:0] cache_wdata;
   logic                  cache_hit, cache_strob;
   logic [DATA_WIDTH-1:0] cache_data;
   logic                  busy;
   logic [CNT_WIDTH-1:0]  hit_cnt, miss_cnt;
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, cache_hit, cache_strob, cache_data,
      input  ack0, ack1, hit_out0, hit_out1, err0, err1, rdata0, rdata1,
             cache_addr, cache_read, cache_write, cache_wdata, busy, hit_cnt, miss_cnt
   );
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, cache_hit, cache_strob, cache_data,
      output ack0, ack1, hit_out0, hit_out1, err0, err1, rdata0, rdata1,
             cache_addr, cache_read, cache_write, cache_wdata, busy, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/cache_port_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the master not granted last wins.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic valid,
   output logic grant
);
   always_comb begin
      valid = req0 | req1;
      grant = (req0 & req1) ? ~last_grant : req1;
   end
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sequencer issuing one cache command at a time for two masters,
// with a completion watchdog and saturating hit/miss statistics.
module cache_port_arbiter
   import cache_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int DATA_WIDTH = DATA_W,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_WIDTH = CNT_W
) (
   input logic clk,
   input logic rst,
   cache_port_arbiter_if.slave bus
);
   localparam int WD_W = $clog2(TIMEOUT);
   arb_state_t state_q, state_d;
   req_cmd_t cmd_q, cmd_d;
   logic last_grant_q, last_grant_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
   logic [1:0] ack_q, ack_d, hit_q, hit_d, err_q, err_d;
   logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic pick_valid, pick_idx, tout, strob_hit, strob_miss;

   rr_pick2 u_pick (
      .req0(bus.req0),
      .req1(bus.req1),
      .last_grant(last_grant_q),
      .valid(pick_valid),
      .grant(pick_idx)
   );

   always_comb begin
      state_d = state_q;
      cmd_d = cmd_q;
      last_grant_d = last_grant_q;
      wd_d = wd_q;
      hit_cnt_d = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      rd_d = 1'b0;
      wr_d = 1'b0;
      ack_d = '0;
      hit_d = hit_q;
      err_d = err_q;
      rdata_d = rdata_q;
      tout = wd_q == WD_W'(TIMEOUT - 1);
      strob_hit = bus.cache_strob & bus.cache_hit;
      strob_miss = bus.cache_strob & ~bus.cache_hit;
      case (state_q)
         IDLE: if (pick_valid) begin
            cmd_d = pick_idx ? {1'b1, bus.we1, bus.addr1, bus.wdata1} : {1'b0, bus.we0, bus.addr0, bus.wdata0};
            rd_d = ~cmd_d.we;
            wr_d = cmd_d.we;
            state_d = ISSUE;
         end
         ISSUE: begin
            wd_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wd_d = wd_q + 1'b1;
            // a strobe arriving on the timeout cycle still completes normally
            if (bus.cache_strob | tout) begin
               ack_d[cmd_q.idx] = 1'b1;
               hit_d[cmd_q.idx] = strob_hit;
               err_d[cmd_q.idx] = ~bus.cache_strob;
               rdata_d[cmd_q.idx] = bus.cache_strob ? bus.cache_data : '0;
               hit_cnt_d = (strob_hit & ~&hit_cnt_q) ? hit_cnt_q + 1'b1 : hit_cnt_q;
               miss_cnt_d = (strob_miss & ~&miss_cnt_q) ? miss_cnt_q + 1'b1 : miss_cnt_q;
               state_d = RESP;
            end
         end
         default: begin
            last_grant_d = cmd_q.idx;
            state_d = IDLE;
         end
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cmd_q <= '0;
         last_grant_q <= 1'b1;
         wd_q <= '0;
         hit_cnt_q <= '0;
         miss_cnt_q <= '0;
         rd_q <= 1'b0;
         wr_q <= 1'b0;
         busy_q <= 1'b0;
         ack_q <= '0;
         hit_q <= '0;
         err_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cmd_q <= cmd_d;
         last_grant_q <= last_grant_d;
         wd_q <= wd_d;
         hit_cnt_q <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
         busy_q <= busy_d;
         ack_q <= ack_d;
         hit_q <= hit_d;
         err_q <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.ack0 = ack_q[0];
   assign bus.ack1 = ack_q[1];
   assign bus.hit_out0 = hit_q[0];
   assign bus.hit_out1 = hit_q[1];
   assign bus.err0 = err_q[0];
   assign bus.err1 = err_q[1];
   assign bus.rdata0 = rdata_q[0];
   assign bus.rdata1 = rdata_q[1];
   assign bus.cache_addr = cmd_q.addr;
   assign bus.cache_wdata = cmd_q.wdata;
   assign bus.cache_read = rd_q;
   assign bus.cache_write = wr_q;
   assign bus.busy = busy_q;
   assign bus.hit_cnt = hit_cnt_q;
   assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: random two-master traffic and a randomly timed cache responder,
// checked cycle by cycle against a transaction-level round-robin/watchdog model.
module tb_cache_port_arbiter;
   localparam int AW = 9, DW = 6, TO = 8, CW = 3, CMAX = (1 << CW) - 1;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
   cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0, n_errs = 0;
   int hc, mc, last;
   logic pend[2];
   logic m_we[2];
   logic [AW-1:0] m_addr[2];
   logic [DW-1:0] m_wd[2];
   logic [DW-1:0] exp_rd[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_req(input int i);
      pend[i] = 1'b1;
      m_we[i] = 1'($urandom);
      m_addr[i] = AW'($urandom);
      m_wd[i] = DW'($urandom);
   endtask

   task automatic drive_masters();
      bus.req0 = pend[0];
      bus.we0 = m_we[0];
      bus.addr0 = m_addr[0];
      bus.wdata0 = m_wd[0];
      bus.req1 = pend[1];
      bus.we1 = m_we[1];
      bus.addr1 = m_addr[1];
      bus.wdata1 = m_wd[1];
   endtask

   task automatic stray_strobe();
      bus.cache_strob = 1'($urandom);
      bus.cache_hit = 1'b1;
      bus.cache_data = DW'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      hc = 0;
      mc = 0;
      last = 1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      check("reset", {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.hit_out0, bus.hit_out1, bus.rdata0, bus.rdata1,
                      bus.cache_read, bus.cache_write, bus.cache_addr, bus.cache_wdata, bus.busy, bus.hit_cnt, bus.miss_cnt}, 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0;
         m_we[i] = 1'b0;
         m_addr[i] = '0;
         m_wd[i] = '0;
      end
      drive_masters();
      bus.cache_strob = 1'b0;
      bus.cache_hit = 1'b0;
      bus.cache_data = '0;
      rst = 1'b1;
      step();
      do_reset();
      for (int r = 0; r < 160; r++) begin
         int win, d, stop;
         bit strobed, aborted;
         logic hit;
         logic [DW-1:0] cd;
         for (int i = 0; i < 2; i++) if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
         if (!pend[0] && !pend[1]) new_req(r % 2);
         drive_masters();
         stray_strobe();
         win = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
         step();
         check("issue", {bus.cache_read, bus.cache_write, bus.cache_addr, bus.cache_wdata, bus.busy, bus.ack0, bus.ack1},
               {!m_we[win], m_we[win], m_addr[win], m_wd[win], 1'b1, 2'b00});
         stray_strobe();
         d = (r % 7 == 3) ? TO - 1 : int'($urandom_range(0, TO + 1));
         stop = d < TO ? d : TO - 1;
         aborted = 1'b0;
         hit = 1'b0;
         cd = '0;
         for (int k = 0; k <= stop; k++) begin
            step();
            check("wait", {bus.ack0, bus.ack1, bus.cache_read, bus.cache_write, bus.cache_addr, bus.busy},
                  {4'b0000, m_addr[win], 1'b1});
            if (r < 60 && k == 2 && stop > 2 && $urandom_range(0, 9) == 0) begin
               aborted = 1'b1;
               break;
            end
            hit = $urandom_range(0, 3) != 0;
            cd = DW'($urandom);
            bus.cache_strob = (k == d);
            bus.cache_hit = hit;
            bus.cache_data = cd;
         end
         if (aborted) begin
            bus.cache_strob = 1'b0;
            do_reset();
            continue;
         end
         step();
         strobed = d < TO;
         if (strobed && hit) hc = (hc < CMAX) ? hc + 1 : CMAX;
         if (strobed && !hit) mc = (mc < CMAX) ? mc + 1 : CMAX;
         exp_rd[win] = strobed ? cd : '0;
         check("ack", {bus.ack0, bus.ack1}, win == 1 ? 2'b01 : 2'b10);
         check("resp", win == 1 ? {bus.hit_out1, bus.err1} : {bus.hit_out0, bus.err0}, {strobed && hit, !strobed});
         check("rdata", {bus.rdata0, bus.rdata1}, {exp_rd[0], exp_rd[1]});
         check("cnt", {bus.hit_cnt, bus.miss_cnt}, {CW'(hc), CW'(mc)});
         last = win;
         pend[win] = 1'b0;
         drive_masters();
         stray_strobe();
         step();
         check("idle", {bus.busy, bus.ack0, bus.ack1, bus.cache_read, bus.cache_write}, 64'd0);
      end
      check("sat", {bus.hit_cnt, bus.miss_cnt}, {CW'(hc), CW'(mc)});
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
